// File: rtl/thermocouple_scanner_if.sv
// SPI master handshake bundle between the scanner and its SPI engine.
interface thermocouple_scanner_if #(
    parameter int NUM_CH = 4
);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic           spi_ena;
    logic [CHW-1:0] ch_sel;
    logic           spi_not_busy;
    logic [31:0]    spi_rx_data;

    modport master (
        output spi_ena,
        output ch_sel,
        input  spi_not_busy,
        input  spi_rx_data
    );

    modport slave (
        input  spi_ena,
        input  ch_sel,
        output spi_not_busy,
        output spi_rx_data
    );
endinterface

// File: rtl/thermocouple_scanner.sv
// Round-robin thermocouple converter scanner with per-channel sample slots.
// Optional over-temperature alarm enabled by defining TC_ALARM_EN.
module thermocouple_scanner #(
    parameter int                 CLK_FREQ    = 400,
    parameter int                 NUM_CH      = 4,
    parameter logic signed [13:0] ALARM_LIMIT = 14'sh0640
) (
    input  logic                   clk,
    input  logic                   rst,
    thermocouple_scanner_if.master spi,
    output logic [14*NUM_CH-1:0]   tc_temp_data,
    output logic [12*NUM_CH-1:0]   junction_temp_data,
    output logic [4*NUM_CH-1:0]    fault_bits,
    output logic [NUM_CH-1:0]      ch_valid,
    output logic                   sample_strobe,
    output logic [NUM_CH-1:0]      alarm
);
    localparam int CW  = $clog2(3*CLK_FREQ+1);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CW-1:0]  PWR_CNT = CW'(3*CLK_FREQ);
    localparam logic [CW-1:0]  GAP_CNT = CW'(CLK_FREQ);
    localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH-1);

    typedef enum logic [2:0] {
        POWERUP,
        REQUEST,
        WAIT,
        CAPTURE,
        GAP
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CHW-1:0] ch_q, ch_d;
    logic           spi_ena;

    logic [13:0] tc_q [NUM_CH];
    logic [11:0] jt_q [NUM_CH];
    logic [3:0]  fb_q [NUM_CH];
    logic [NUM_CH-1:0] valid_q;

    logic        frm_fault;
    logic [13:0] frm_tc;
    logic [11:0] frm_jt;
    logic [3:0]  frm_fb;
    logic        unused_bits;

    assign frm_fault   = spi.spi_rx_data[16];
    assign frm_tc      = spi.spi_rx_data[31:18];
    assign frm_jt      = spi.spi_rx_data[15:4];
    assign frm_fb      = {spi.spi_rx_data[16], spi.spi_rx_data[2:0]};
    assign unused_bits = ^{spi.spi_rx_data[17], spi.spi_rx_data[3]};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ch_d          = ch_q;
        spi_ena       = 1'b0;
        sample_strobe = 1'b0;
        case (state_q)
            POWERUP: begin
                if (cnt_q < PWR_CNT) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d   = '0;
                    state_d = REQUEST;
                end
            end
            REQUEST: begin
                if (spi.spi_not_busy) begin
                    spi_ena = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (spi.spi_not_busy) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                sample_strobe = 1'b1;
                state_d       = GAP;
            end
            GAP: begin
                if (cnt_q < GAP_CNT) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d   = '0;
                    ch_d    = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
                    state_d = REQUEST;
                end
            end
            default: state_d = REQUEST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= POWERUP;
            cnt_q   <= '0;
            ch_q    <= '0;
            tc_q    <= '{default: '0};
            jt_q    <= '{default: '0};
            fb_q    <= '{default: '0};
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            if (state_q == CAPTURE) begin
                fb_q[ch_q] <= frm_fb;
                // A faulted frame carries no usable temperature.
                if (frm_fault) begin
                    valid_q[ch_q] <= 1'b0;
                end else begin
                    tc_q[ch_q]    <= frm_tc;
                    jt_q[ch_q]    <= frm_jt;
                    valid_q[ch_q] <= 1'b1;
                end
            end
        end
    end

`ifdef TC_ALARM_EN
    logic [NUM_CH-1:0] alarm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_q <= '0;
        end else if (state_q == CAPTURE && !frm_fault) begin
            alarm_q[ch_q] <= $signed(frm_tc) > ALARM_LIMIT;
        end
    end

    assign alarm = alarm_q;
`else
    logic unused_limit;
    assign unused_limit = ^ALARM_LIMIT;
    assign alarm        = '0;
`endif

    for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
        assign tc_temp_data[14*k +: 14]       = tc_q[k];
        assign junction_temp_data[12*k +: 12] = jt_q[k];
        assign fault_bits[4*k +: 4]           = fb_q[k];
    end

    assign ch_valid    = valid_q;
    assign spi.spi_ena = spi_ena;
    assign spi.ch_sel  = ch_q;
endmodule
